// File: rtl/axi_fifo_burst_reader.sv
// Drains a BRAM FIFO into tlast-framed bursts of BURST_LEN beats, with a
// timeout-driven short burst so that trailing data is not stranded.
module axi_fifo_burst_reader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 1024,
    parameter int TMR_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    input  logic [15:0]      occupied,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    output logic             o_tlast,
    input  logic             o_tready,
    output logic             busy,
    output logic [31:0]      burst_count,
    output logic [15:0]      flush_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [15:0] BLEN = 16'(BURST_LEN);
    localparam bit FLUSH_EN = (TIMEOUT != 0);
    localparam logic [TMR_W-1:0] TMR_LAST =
        TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [0:0]       state;
    logic [15:0]      beats_left;
    logic [TMR_W-1:0] timer;
    logic             int_ready;
    logic             accept;
    logic             last_out;

    assign int_ready = o_tready | ~o_tvalid;
    assign i_tready  = int_ready & (state == ST_BURST) & (beats_left != 16'd0);
    assign accept    = i_tvalid & i_tready;
    assign last_out  = o_tvalid & o_tready & o_tlast;
    assign busy      = (state == ST_BURST);

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            o_tdata     <= '0;
            o_tvalid    <= 1'b0;
            o_tlast     <= 1'b0;
            state       <= ST_IDLE;
            beats_left  <= 16'd0;
            timer       <= '0;
            burst_count <= 32'd0;
            flush_count <= 16'd0;
        end else begin
            if (int_ready) begin
                o_tvalid <= accept;
                if (accept) begin
                    o_tdata <= i_tdata;
                    o_tlast <= (beats_left == 16'd1);
                end else begin
                    o_tlast <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    // Threshold is checked first so it wins over a same-cycle timeout
                    if (occupied >= BLEN) begin
                        beats_left <= BLEN;
                        state      <= ST_BURST;
                        timer      <= '0;
                    end else if (FLUSH_EN && occupied != 16'd0 &&
                                 timer == TMR_LAST) begin
                        beats_left  <= occupied;
                        state       <= ST_BURST;
                        timer       <= '0;
                        flush_count <= flush_count + 16'd1;
                    end else if (occupied != 16'd0) begin
                        timer <= timer + 1'b1;
                    end else begin
                        timer <= '0;
                    end
                end
                ST_BURST: begin
                    if (accept) begin
                        beats_left <= beats_left - 16'd1;
                    end
                    // Stay busy until the final beat has actually left the output register
                    if (last_out) begin
                        state       <= ST_IDLE;
                        burst_count <= burst_count + 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_fifo_burst_reader.sv
// Directed bench for axi_fifo_burst_reader: a queue models the BRAM FIFO,
// one reader with TIMEOUT=16 and one with flushing disabled.
module tb_axi_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_a;
    logic        clear_b;
    logic [31:0] i_tdata;
    logic        i_tvalid;
    logic [15:0] occupied;
    logic        o_tready;
    logic        sel;

    logic        i_tready_a, i_tready_b;
    logic [31:0] o_tdata_a, o_tdata_b;
    logic        o_tvalid_a, o_tvalid_b;
    logic        o_tlast_a, o_tlast_b;
    logic        busy_a, busy_b;
    logic [31:0] bcnt_a, bcnt_b;
    logic [15:0] fcnt_a, fcnt_b;

    wire        s_i_tready = sel ? i_tready_b : i_tready_a;
    wire [31:0] s_o_tdata  = sel ? o_tdata_b : o_tdata_a;
    wire        s_o_tvalid = sel ? o_tvalid_b : o_tvalid_a;
    wire        s_o_tlast  = sel ? o_tlast_b : o_tlast_a;
    wire        s_busy     = sel ? busy_b : busy_a;
    wire [31:0] s_bcnt     = sel ? bcnt_b : bcnt_a;
    wire [15:0] s_fcnt     = sel ? fcnt_b : fcnt_a;

    axi_fifo_burst_reader #(
        .WIDTH(32), .BURST_LEN(4), .TIMEOUT(16), .TMR_W(16)
    ) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear_a),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready_a),
        .occupied(occupied),
        .o_tdata(o_tdata_a), .o_tvalid(o_tvalid_a), .o_tlast(o_tlast_a),
        .o_tready(o_tready), .busy(busy_a),
        .burst_count(bcnt_a), .flush_count(fcnt_a)
    );

    axi_fifo_burst_reader #(
        .WIDTH(32), .BURST_LEN(4), .TIMEOUT(0), .TMR_W(16)
    ) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear_b),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready_b),
        .occupied(occupied),
        .o_tdata(o_tdata_b), .o_tvalid(o_tvalid_b), .o_tlast(o_tlast_b),
        .o_tready(o_tready), .busy(busy_b),
        .burst_count(bcnt_b), .flush_count(fcnt_b)
    );

    always #5 clk = ~clk;

    logic [31:0] fq[$];
    logic [31:0] out_q[$];
    logic        last_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          stab_err = 0;
    logic        toggle = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    logic        pop;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        i_tvalid = (fq.size() != 0);
        if (fq.size() != 0) i_tdata = fq[0];
        occupied = 16'(fq.size());
    endtask

    task automatic push(logic [31:0] w);
        fq.push_back(w);
        drive();
    endtask

    task automatic tick();
        @(negedge clk);
        pop = i_tvalid && s_i_tready;
        if (s_o_tvalid && o_tready) begin
            out_q.push_back(s_o_tdata);
            last_q.push_back(s_o_tlast);
        end
        if (stall_prev && (!s_o_tvalid || s_o_tdata !== stall_data))
            stab_err++;
        stall_prev = s_o_tvalid && !o_tready;
        stall_data = s_o_tdata;
        @(posedge clk);
        #1;
        if (pop) fq.delete(0);
        if (toggle) o_tready = !o_tready;
        drive();
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_burst(string tag, int base, int n, int blen);
        check({tag, "_beats"}, 32'(out_q.size()), 32'(n));
        if (out_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check({tag, "_data"}, out_q[i], 32'(base + i));
                check({tag, "_last"}, 32'(last_q[i]),
                      32'(((i % blen) == blen - 1) || (i == n - 1)));
            end
        end
        out_q.delete();
        last_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        clear_a = 1'b0;
        clear_b = 1'b1;
        sel = 1'b0;
        o_tready = 1'b1;
        i_tdata = '0;
        drive();
        run(3);
        check("rst_tvalid", 32'(o_tvalid_a), 32'd0);
        check("rst_tlast", 32'(o_tlast_a), 32'd0);
        check("rst_tdata", o_tdata_a, 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_bcnt", bcnt_a, 32'd0);
        check("rst_fcnt", 32'(fcnt_a), 32'd0);
        check("rst_itready", 32'(i_tready_a), 32'd0);
        reset = 1'b0;
        run(2);

        // two full bursts from 8 words
        for (int i = 0; i < 8; i++) push(32'(i));
        run(30);
        check_burst("b8", 0, 8, 4);
        check("b8_bcnt", s_bcnt, 32'd2);
        check("b8_fcnt", 32'(s_fcnt), 32'd0);
        check("b8_busy", 32'(s_busy), 32'd0);

        // timeout flush of 3 words
        push(32'd100); push(32'd101); push(32'd102);
        run(15);
        check("to_busy15", 32'(s_busy), 32'd0);
        check("to_fcnt15", 32'(s_fcnt), 32'd0);
        tick();
        check("to_busy16", 32'(s_busy), 32'd1);
        check("to_fcnt16", 32'(s_fcnt), 32'd1);
        tick();
        check("to_lat_valid", 32'(s_o_tvalid), 32'd1);
        check("to_lat_data", s_o_tdata, 32'd100);
        run(10);
        check_burst("to", 100, 3, 4);
        check("to_bcnt", s_bcnt, 32'd3);
        check("to_fcnt", 32'(s_fcnt), 32'd1);

        // backpressure toggling
        for (int i = 0; i < 4; i++) push(32'(10 + i));
        toggle = 1'b1;
        run(20);
        toggle = 1'b0;
        o_tready = 1'b1;
        run(5);
        check_burst("tg", 10, 4, 4);
        check("tg_stable", 32'(stab_err), 32'd0);
        check("tg_bcnt", s_bcnt, 32'd4);

        // threshold and timeout in the same cycle
        push(32'd20); push(32'd21); push(32'd22);
        run(15);
        check("tie_busy", 32'(s_busy), 32'd0);
        push(32'd23);
        tick();
        check("tie_start", 32'(s_busy), 32'd1);
        check("tie_fcnt_now", 32'(s_fcnt), 32'd1);
        run(12);
        check_burst("tie", 20, 4, 4);
        check("tie_fcnt", 32'(s_fcnt), 32'd1);
        check("tie_bcnt", s_bcnt, 32'd5);

        // clear mid-burst
        for (int i = 0; i < 4; i++) push(32'(30 + i));
        for (int k = 0; k < 20 && out_q.size() < 2; k++) tick();
        check("clr_wait", 32'(out_q.size()), 32'd2);
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        fq.delete();
        drive();
        check("clr_tvalid", 32'(s_o_tvalid), 32'd0);
        check("clr_tlast", 32'(s_o_tlast), 32'd0);
        check("clr_busy", 32'(s_busy), 32'd0);
        check("clr_bcnt", s_bcnt, 32'd0);
        check("clr_fcnt", 32'(s_fcnt), 32'd0);
        out_q.delete();
        last_q.delete();
        for (int i = 0; i < 4; i++) push(32'(40 + i));
        run(12);
        check_burst("pc", 40, 4, 4);
        check("pc_bcnt", s_bcnt, 32'd1);

        // flushing disabled
        sel = 1'b1;
        clear_a = 1'b1;
        clear_b = 1'b0;
        push(32'd50); push(32'd51); push(32'd52);
        run(5000);
        check("nt_beats", 32'(out_q.size()), 32'd0);
        check("nt_busy", 32'(s_busy), 32'd0);
        check("nt_occ", 32'(occupied), 32'd3);
        push(32'd53);
        run(12);
        check_burst("nt", 50, 4, 4);
        check("nt_bcnt", s_bcnt, 32'd1);
        check("nt_fcnt", 32'(s_fcnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
